// File: rtl/rca_pipelined.sv
// rtl/rca_pipelined.sv - pipelined ripple-carry adder/subtractor, one SEG_WIDTH segment per stage
module rca_pipelined #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);
    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cry;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] in_v;
    logic [STAGES-1:0] in_c;
    logic [WIDTH-1:0]  in_a    [STAGES];
    logic [WIDTH-1:0]  in_b    [STAGES];
    logic [WIDTH-1:0]  in_sum  [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic [SEG_WIDTH:0] seg    [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic              nxt_ovf;
    logic              advance;

    // Operands of the last stage are fully consumed there and never forwarded.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[LAST], b_q[LAST]};

    assign advance  = !vld[LAST] || i_ready;
    assign o_ready  = advance;
    assign o_valid  = vld[LAST];
    assign o_result = {cry[LAST], sum_q[LAST]};
    assign o_overflow = ovf_q;

    always_comb begin
        in_v[0]   = i_valid;
        in_c[0]   = i_sub | i_carry;
        in_a[0]   = i_add_term1;
        in_b[0]   = i_sub ? ~i_add_term2 : i_add_term2;
        in_sum[0] = '0;
        for (int s = 1; s < STAGES; s++) begin
            in_v[s]   = vld[s-1];
            in_c[s]   = cry[s-1];
            in_a[s]   = a_q[s-1];
            in_b[s]   = b_q[s-1];
            in_sum[s] = sum_q[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            seg[s] = {1'b0, in_a[s][s*SEG_WIDTH +: SEG_WIDTH]}
                   + {1'b0, in_b[s][s*SEG_WIDTH +: SEG_WIDTH]}
                   + {{SEG_WIDTH{1'b0}}, in_c[s]};
            nxt_sum[s] = in_sum[s];
            nxt_sum[s][s*SEG_WIDTH +: SEG_WIDTH] = seg[s][SEG_WIDTH-1:0];
            nxt_c[s] = seg[s][SEG_WIDTH];
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        nxt_ovf = in_a[LAST][WIDTH-1] ^ in_b[LAST][WIDTH-1]
                ^ nxt_sum[LAST][WIDTH-1] ^ nxt_c[LAST];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld   <= '0;
            cry   <= '0;
            ovf_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                sum_q[s] <= '0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
            end
        end else if (advance) begin
            vld   <= in_v;
            cry   <= nxt_c;
            ovf_q <= nxt_ovf;
            for (int s = 0; s < STAGES; s++) begin
                sum_q[s] <= nxt_sum[s];
                a_q[s]   <= in_a[s];
                b_q[s]   <= in_b[s];
            end
        end
    end
endmodule

// File: tb/tb_rca_pipelined.sv
// tb/tb_rca_pipelined.sv - randomized scoreboard bench for rca_pipelined
module tb_rca_pipelined;
    localparam int W  = 64;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1, carry = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic o_ready, o_valid, o_ovf;
    logic [W:0] o_res;

    logic v34 = 1'b0, v32 = 1'b0;
    logic [33:0] a34 = '0, b34 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic r34_ready, r34_valid, r34_ovf, r32_ready, r32_valid, r32_ovf;
    logic [34:0] r34_res;
    logic [32:0] r32_res;

    rca_pipelined u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(o_ready),
        .i_add_term1(a), .i_add_term2(b), .i_carry(carry), .i_sub(sub),
        .o_valid(o_valid), .i_ready(out_ready), .o_result(o_res), .o_overflow(o_ovf)
    );

    rca_pipelined #(.WIDTH(34), .SEG_WIDTH(17)) u_dut34 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v34), .o_ready(r34_ready),
        .i_add_term1(a34), .i_add_term2(b34), .i_carry(1'b0), .i_sub(1'b0),
        .o_valid(r34_valid), .i_ready(1'b1), .o_result(r34_res), .o_overflow(r34_ovf)
    );

    rca_pipelined #(.WIDTH(32), .SEG_WIDTH(8)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(r32_ready),
        .i_add_term1(a32), .i_add_term2(b32), .i_carry(1'b0), .i_sub(1'b0),
        .o_valid(r32_valid), .i_ready(1'b1), .o_result(r32_res), .o_overflow(r32_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [W+1:0] exp_q[$];
    logic prev_stall = 1'b0;
    logic [W:0] prev_res = '0;
    logic prev_ovf = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {overflow, carry/no-borrow, sum} from plain arithmetic and a signed range test.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W:0] full;
        logic signed [W:0] sfull, maxp, minn;
        maxp = {2'b00, {(W-1){1'b1}}};
        minn = {2'b11, {(W-1){1'b0}}};
        if (s) begin
            full[W-1:0] = x - y;
            full[W]     = (x >= y);
            sfull = $signed({x[W-1], x}) - $signed({y[W-1], y});
        end else begin
            full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            sfull = $signed({x[W-1], x}) + $signed({y[W-1], y}) + $signed({{W{1'b0}}, c});
        end
        return {(sfull > maxp) || (sfull < minn), full};
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input logic rdy);
        logic [W+1:0] e;
        in_valid = v; a = x; b = y; carry = c; sub = s; out_ready = rdy;
        #1;
        if (prev_stall) begin
            check("hold_valid", o_valid, 1'b1);
            check("hold_result", {o_ovf, o_res}, {prev_ovf, prev_res});
        end
        check("o_ready", o_ready, !o_valid || rdy);
        if (o_valid && rdy) begin
            if (exp_q.size() == 0) check("unexpected_result", o_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("result", {o_ovf, o_res}, e);
            end
        end
        if (v && (!o_valid || rdy)) exp_q.push_back(model(x, y, c, s));
        prev_stall = o_valid && !rdy;
        prev_res = o_res;
        prev_ovf = o_ovf;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (ST + 1) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat34, lat32;
        logic v;
        logic hist[64];
        logic [34:0] c34;
        logic [32:0] c32;
        logic o34, o32;

        #3;
        check("rst_valid", o_valid, 1'b0);
        check("rst_result", o_res, '0);
        check("rst_ready", o_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // full carry ripple plus latency
        cycle(1'b1, {W{1'b1}}, '0, 1'b1, 1'b0, 1'b1);
        lat = 1;
        while (!o_valid && lat < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        check("latency", lat, ST);
        check("ripple_result", o_res, {1'b1, {W{1'b0}}});
        check("ripple_ovf", o_ovf, 1'b0);
        drain();

        // subtract cases, carry-in must be ignored
        cycle(1'b1, 64'd5, 64'd7, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b1);
        drain();

        // streaming with bubbles, o_valid pattern must follow i_valid by ST edges
        for (int i = 0; i < 40; i++) begin
            v = (i < 8) ? 1'b1 : ((i < 30) ? ($urandom_range(0, 2) != 0) : 1'b0);
            check("valid_gap", o_valid, (i >= ST) ? hist[i-ST] : 1'b0);
            hist[i] = v;
            cycle(v, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1),
                  $urandom_range(0, 1), 1'b1);
        end
        check("stream_drained", exp_q.size(), 0);

        // backpressure on a full pipeline, release accepts on the same edge
        repeat (ST) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
        drain();

        // random valid and ready mix
        repeat (300)
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0);
        drain();

        // asynchronous reset mid-cycle with ops in flight and a stalled output
        repeat (ST) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 1'b0);
        check("async_rst_result", o_res, '0);
        check("async_rst_ovf", o_ovf, 1'b0);
        check("async_rst_ready", o_ready, 1'b1);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ST + 2; i++) begin
            check("no_stale", o_valid, 1'b0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end

        // parameter sweep instances
        v34 = 1'b1; a34 = 34'h3_FFFF_FFFF; b34 = 34'd1;
        v32 = 1'b1; a32 = 32'hFFFF_FFFF;   b32 = 32'd1;
        @(negedge clk);
        v34 = 1'b0; v32 = 1'b0;
        lat34 = 0; lat32 = 0; c34 = '0; c32 = '0; o34 = 1'b1; o32 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (r34_valid && lat34 == 0) begin lat34 = e; c34 = r34_res; o34 = r34_ovf; end
            if (r32_valid && lat32 == 0) begin lat32 = e; c32 = r32_res; o32 = r32_ovf; end
            @(negedge clk);
        end
        check("w34_latency", lat34, 2);
        check("w34_result", c34, 35'h4_0000_0000);
        check("w34_ovf", o34, 1'b0);
        check("w32_latency", lat32, 4);
        check("w32_result", c32, 33'h1_0000_0000);
        check("w32_ovf", o32, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
